// File: rtl/sd_spi_card_responder_if.sv
// SD SPI link plus the block-write byte port of the card responder.
// master: the host/bench side; slave: the emulated card.
interface sd_spi_card_responder_if;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic        initialized;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_first;
    logic        wr_last;
    logic [31:0] wr_addr;
    logic        wr_abort;

    modport master (
        output sclk, cs_n, mosi,
        input  miso, initialized, wr_valid, wr_data, wr_first, wr_last, wr_addr, wr_abort
    );

    modport slave (
        input  sclk, cs_n, mosi,
        output miso, initialized, wr_valid, wr_data, wr_first, wr_last, wr_addr, wr_abort
    );
endinterface

// File: rtl/sd_spi_card_responder.sv
// SPI-mode SD card emulator. Oversamples the SPI pins in the clk domain,
// decodes 6-byte commands, answers R1/R2/R3/R7 and streams CMD24 payloads.
//
// state      | meaning
// -----------+---------------------------------------------------------
// CMD_WAIT   | waiting for a byte with [7:6]==01 (command start)
// CMD_ARGS   | collecting 4 argument bytes and the CRC byte
// NCR        | sending NCR_BYTES x 0xFF before the response
// RESP       | sending the response bytes
// TOKEN_WAIT | CMD24 accepted, waiting for the 0xFE start token
// DATA_RX    | 512 payload bytes then 2 CRC bytes
// DRESP      | sending data response 0x05
// BUSY       | sending BUSY_BYTES x 0x00
module sd_spi_card_responder #(
    parameter int ACMD41_BUSY = 2,
    parameter int NCR_BYTES   = 1,
    parameter int BUSY_BYTES  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    sd_spi_card_responder_if.slave      bus
);
    typedef enum logic [2:0] {
        CMD_WAIT, CMD_ARGS, NCR, RESP, TOKEN_WAIT, DATA_RX, DRESP, BUSY
    } state_t;

    localparam logic [7:0] ACMD_BUSY_C = 8'(ACMD41_BUSY);
    localparam logic [3:0] NCR_LAST    = 4'(NCR_BYTES - 1);
    localparam logic [7:0] BUSY_LAST   = 8'(BUSY_BYTES - 1);

    logic [1:0] sclk_sync, cs_sync, mosi_sync;
    logic       sclk_q;
    logic       sclk_rise, sclk_fall, cs_hi;

    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] rx_byte;
    logic       byte_done;
    logic       load_pending;
    logic [7:0] tx_shift;
    logic       miso_q;

    state_t      state_q, state_d;
    logic [7:0]  tx_next_q, tx_next_d;
    logic [5:0]  cmd_idx_q, cmd_idx_d;
    logic [31:0] arg_q, arg_d;
    logic [2:0]  args_left_q, args_left_d;
    logic [3:0]  ncr_left_q, ncr_left_d;
    logic [39:0] resp_buf_q, resp_buf_d;
    logic [2:0]  resp_left_q, resp_left_d;
    logic [9:0]  data_left_q, data_left_d;
    logic [7:0]  busy_left_q, busy_left_d;
    logic        take_data_q, take_data_d;
    logic        app_cmd_q, app_cmd_d;
    logic        idle_q, idle_d;
    logic        init_q, init_d;
    logic [7:0]  acmd_cnt_q, acmd_cnt_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic        wr_valid_q, wr_valid_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        wr_first_q, wr_first_d;
    logic        wr_last_q, wr_last_d;
    logic        wr_abort_q, wr_abort_d;

    logic [39:0] dec_buf;
    logic [2:0]  dec_len;
    logic        dec_data;
    logic [7:0]  r1_i, r1_ill;

    // Two-stage synchronizers for the asynchronous SPI pins and sclk history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b11;
            sclk_q    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], bus.sclk};
            cs_sync   <= {cs_sync[0], bus.cs_n};
            mosi_sync <= {mosi_sync[0], bus.mosi};
            sclk_q    <= sclk_sync[1];
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_q;
    assign sclk_fall = ~sclk_sync[1] & sclk_q;
    assign cs_hi     = cs_sync[1];

    // Bit layer: shift in on sclk rise, shift out on sclk fall; the fall
    // after a byte boundary loads the byte the FSM chose in tx_next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt      <= 3'd0;
            rx_shift     <= 7'd0;
            rx_byte      <= 8'd0;
            byte_done    <= 1'b0;
            load_pending <= 1'b0;
            tx_shift     <= 8'hFF;
            miso_q       <= 1'b1;
        end else begin
            byte_done <= 1'b0;
            if (cs_hi) begin
                bit_cnt      <= 3'd0;
                load_pending <= 1'b0;
                tx_shift     <= 8'hFF;
                miso_q       <= 1'b1;
            end else begin
                if (sclk_rise) begin
                    rx_shift <= {rx_shift[5:0], mosi_sync[1]};
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_byte      <= {rx_shift, mosi_sync[1]};
                        byte_done    <= 1'b1;
                        load_pending <= 1'b1;
                    end
                end
                if (sclk_fall) begin
                    if (load_pending) begin
                        tx_shift     <= tx_next_q;
                        miso_q       <= tx_next_q[7];
                        load_pending <= 1'b0;
                    end else begin
                        tx_shift <= {tx_shift[6:0], 1'b1};
                        miso_q   <= tx_shift[6];
                    end
                end
            end
        end
    end

    assign r1_i   = {7'b0, idle_q};
    assign r1_ill = {5'b0, 1'b1, 1'b0, idle_q};

    // Response bytes for the command just received (left-aligned, len-1).
    always_comb begin
        dec_buf  = {r1_ill, 32'h0};
        dec_len  = 3'd0;
        dec_data = 1'b0;
        case (cmd_idx_q)
            6'd0:  dec_buf = {8'h01, 32'h0};
            6'd8: begin
                dec_buf = {r1_i, 16'h0000, 4'h0, arg_q[11:8], arg_q[7:0]};
                dec_len = 3'd4;
            end
            6'd13: begin
                dec_buf = 40'h0;
                dec_len = 3'd1;
            end
            6'd16: dec_buf = {(arg_q == 32'd512) ? r1_i : (r1_i | 8'h40), 32'h0};
            6'd24: begin
                if (init_q) begin
                    dec_buf  = 40'h0;
                    dec_data = 1'b1;
                end
            end
            6'd41: begin
                if (app_cmd_q)
                    dec_buf = {(acmd_cnt_q < ACMD_BUSY_C) ? 8'h01 : 8'h00, 32'h0};
            end
            6'd55: dec_buf = {r1_i, 32'h0};
            6'd58: begin
                dec_buf = {r1_i, 32'hC0FF_8000};
                dec_len = 3'd4;
            end
            6'd59: dec_buf = {r1_i, 32'h0};
            default: ;
        endcase
    end

    // Byte-level protocol FSM: next state, next tx byte and side effects.
    always_comb begin
        state_d     = state_q;
        tx_next_d   = tx_next_q;
        cmd_idx_d   = cmd_idx_q;
        arg_d       = arg_q;
        args_left_d = args_left_q;
        ncr_left_d  = ncr_left_q;
        resp_buf_d  = resp_buf_q;
        resp_left_d = resp_left_q;
        data_left_d = data_left_q;
        busy_left_d = busy_left_q;
        take_data_d = take_data_q;
        app_cmd_d   = app_cmd_q;
        idle_d      = idle_q;
        init_d      = init_q;
        acmd_cnt_d  = acmd_cnt_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_valid_d  = 1'b0;
        wr_first_d  = 1'b0;
        wr_last_d   = 1'b0;
        wr_abort_d  = 1'b0;
        if (cs_hi) begin
            state_d    = CMD_WAIT;
            tx_next_d  = 8'hFF;
            wr_abort_d = (state_q == DATA_RX);
        end else if (byte_done) begin
            tx_next_d = 8'hFF;
            case (state_q)
                CMD_WAIT: begin
                    if (rx_byte[7:6] == 2'b01) begin
                        cmd_idx_d   = rx_byte[5:0];
                        args_left_d = 3'd4;
                        state_d     = CMD_ARGS;
                    end
                end
                CMD_ARGS: begin
                    if (args_left_q != 3'd0) begin
                        arg_d       = {arg_q[23:0], rx_byte};
                        args_left_d = args_left_q - 3'd1;
                    end else begin
                        state_d     = NCR;
                        ncr_left_d  = NCR_LAST;
                        resp_buf_d  = dec_buf;
                        resp_left_d = dec_len;
                        take_data_d = dec_data;
                        app_cmd_d   = 1'b0;
                        case (cmd_idx_q)
                            6'd0: begin
                                idle_d     = 1'b1;
                                init_d     = 1'b0;
                                acmd_cnt_d = 8'd0;
                            end
                            6'd55: app_cmd_d = 1'b1;
                            6'd41: begin
                                if (app_cmd_q) begin
                                    if (acmd_cnt_q < ACMD_BUSY_C) begin
                                        acmd_cnt_d = acmd_cnt_q + 8'd1;
                                    end else begin
                                        idle_d = 1'b0;
                                        init_d = 1'b1;
                                    end
                                end
                            end
                            6'd24: if (init_q) wr_addr_d = arg_q;
                            default: ;
                        endcase
                    end
                end
                NCR: begin
                    if (ncr_left_q == 4'd0) begin
                        state_d    = RESP;
                        tx_next_d  = resp_buf_q[39:32];
                        resp_buf_d = {resp_buf_q[31:0], 8'hFF};
                    end else begin
                        ncr_left_d = ncr_left_q - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_left_q == 3'd0) begin
                        state_d = take_data_q ? TOKEN_WAIT : CMD_WAIT;
                    end else begin
                        tx_next_d   = resp_buf_q[39:32];
                        resp_buf_d  = {resp_buf_q[31:0], 8'hFF};
                        resp_left_d = resp_left_q - 3'd1;
                    end
                end
                TOKEN_WAIT: begin
                    if (rx_byte == 8'hFE) begin
                        state_d     = DATA_RX;
                        data_left_d = 10'd513;
                    end
                end
                DATA_RX: begin
                    if (data_left_q >= 10'd2) begin
                        wr_valid_d = 1'b1;
                        wr_data_d  = rx_byte;
                        wr_first_d = (data_left_q == 10'd513);
                        wr_last_d  = (data_left_q == 10'd2);
                    end
                    if (data_left_q == 10'd0) begin
                        state_d   = DRESP;
                        tx_next_d = 8'h05;
                    end else begin
                        data_left_d = data_left_q - 10'd1;
                    end
                end
                DRESP: begin
                    state_d     = BUSY;
                    tx_next_d   = 8'h00;
                    busy_left_d = BUSY_LAST;
                end
                BUSY: begin
                    if (busy_left_q == 8'd0) begin
                        state_d = CMD_WAIT;
                    end else begin
                        busy_left_d = busy_left_q - 8'd1;
                        tx_next_d   = 8'h00;
                    end
                end
                default: state_d = CMD_WAIT;
            endcase
        end
    end

    // FSM and card-status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= CMD_WAIT;
            tx_next_q   <= 8'hFF;
            cmd_idx_q   <= 6'd0;
            arg_q       <= 32'd0;
            args_left_q <= 3'd0;
            ncr_left_q  <= 4'd0;
            resp_buf_q  <= 40'hFF_FFFF_FFFF;
            resp_left_q <= 3'd0;
            data_left_q <= 10'd0;
            busy_left_q <= 8'd0;
            take_data_q <= 1'b0;
            app_cmd_q   <= 1'b0;
            idle_q      <= 1'b1;
            init_q      <= 1'b0;
            acmd_cnt_q  <= 8'd0;
            wr_addr_q   <= 32'd0;
            wr_valid_q  <= 1'b0;
            wr_data_q   <= 8'd0;
            wr_first_q  <= 1'b0;
            wr_last_q   <= 1'b0;
            wr_abort_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_next_q   <= tx_next_d;
            cmd_idx_q   <= cmd_idx_d;
            arg_q       <= arg_d;
            args_left_q <= args_left_d;
            ncr_left_q  <= ncr_left_d;
            resp_buf_q  <= resp_buf_d;
            resp_left_q <= resp_left_d;
            data_left_q <= data_left_d;
            busy_left_q <= busy_left_d;
            take_data_q <= take_data_d;
            app_cmd_q   <= app_cmd_d;
            idle_q      <= idle_d;
            init_q      <= init_d;
            acmd_cnt_q  <= acmd_cnt_d;
            wr_addr_q   <= wr_addr_d;
            wr_valid_q  <= wr_valid_d;
            wr_data_q   <= wr_data_d;
            wr_first_q  <= wr_first_d;
            wr_last_q   <= wr_last_d;
            wr_abort_q  <= wr_abort_d;
        end
    end

    assign bus.miso        = miso_q;
    assign bus.initialized = init_q;
    assign bus.wr_valid    = wr_valid_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.wr_first    = wr_first_q;
    assign bus.wr_last     = wr_last_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_abort    = wr_abort_q;
endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Directed bench for the SD SPI card responder: drives mode-0 SPI as the
// host and checks responses and the write byte port against fixed values.
module tb_sd_spi_card_responder;
    logic clk = 1'b0;
    logic rst;
    sd_spi_card_responder_if bus();

    sd_spi_card_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int         valid_cnt, abort_cnt, first_cnt, last_cnt, data_err;
    logic [7:0] first_data, last_data;

    // Write-port monitor; payload byte n is expected to equal n mod 256.
    always @(negedge clk) begin
        if (bus.wr_valid === 1'b1) begin
            if (bus.wr_data !== valid_cnt[7:0]) data_err++;
            if (bus.wr_first === 1'b1) begin
                first_cnt++;
                first_data = bus.wr_data;
            end
            if (bus.wr_last === 1'b1) begin
                last_cnt++;
                last_data = bus.wr_data;
            end
            valid_cnt++;
        end
        if (bus.wr_abort === 1'b1) abort_cnt++;
    end

    task automatic clear_mon();
        valid_cnt = 0; abort_cnt = 0; first_cnt = 0; last_cnt = 0; data_err = 0;
        first_data = 8'hxx; last_data = 8'hxx;
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            bus.mosi = tx[i];
            #50;
            rx[i] = bus.miso;
            bus.sclk = 1'b1;
            #50;
            bus.sclk = 1'b0;
        end
    endtask

    task automatic cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
        logic [7:0] d;
        xfer({2'b01, idx}, d);
        xfer(arg[31:24], d);
        xfer(arg[23:16], d);
        xfer(arg[15:8], d);
        xfer(arg[7:0], d);
        xfer(crc, d);
    endtask

    task automatic get_resp(input int n, output logic [39:0] r);
        logic [7:0] d;
        xfer(8'hFF, d);
        r = 40'h0;
        for (int i = 0; i < n; i++) begin
            xfer(8'hFF, d);
            r = {r[31:0], d};
        end
    endtask

    task automatic test_reset();
        int noisy;
        rst = 1'b1; bus.cs_n = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b1;
        #100;
        rst = 1'b0;
        #20;
        total++; if (bus.miso !== 1'b1) begin bad++; $display("FAIL reset_miso got=%b want=1", bus.miso); end
        total++; if (bus.initialized !== 1'b0) begin bad++; $display("FAIL reset_init got=%b want=0", bus.initialized); end
        total++; if (bus.wr_valid !== 1'b0) begin bad++; $display("FAIL reset_wr_valid got=%b want=0", bus.wr_valid); end
        noisy = 0;
        for (int i = 0; i < 100; i++) begin
            bus.mosi = i[0];
            #50;
            if (bus.miso !== 1'b1 || bus.wr_valid !== 1'b0 || bus.initialized !== 1'b0 || bus.wr_abort !== 1'b0) noisy++;
            bus.sclk = 1'b1;
            #50;
            bus.sclk = 1'b0;
        end
        total++; if (noisy !== 0) begin bad++; $display("FAIL reset_quiet got=%0d want=0", noisy); end
    endtask

    task automatic test_cmd0();
        logic [7:0] d;
        bus.cs_n = 1'b0;
        #50;
        cmd(6'd0, 32'h0, 8'h95);
        xfer(8'hFF, d);
        total++; if (d !== 8'hFF) begin bad++; $display("FAIL cmd0_ncr got=%h want=ff", d); end
        xfer(8'hFF, d);
        total++; if (d !== 8'h01) begin bad++; $display("FAIL cmd0_r1 got=%h want=01", d); end
        total++; if (bus.initialized !== 1'b0) begin bad++; $display("FAIL cmd0_init got=%b want=0", bus.initialized); end
    endtask

    task automatic test_init();
        logic [39:0] r;
        logic [7:0]  want;
        cmd(6'd8, 32'h0000_01AA, 8'h87);
        get_resp(5, r);
        total++; if (r !== 40'h01_0000_01AA) begin bad++; $display("FAIL cmd8_r7 got=%h want=01000001aa", r); end
        for (int k = 0; k < 3; k++) begin
            cmd(6'd55, 32'h0, 8'hFF);
            get_resp(1, r);
            total++; if (r[7:0] !== 8'h01) begin bad++; $display("FAIL cmd55_r1 got=%h want=01", r[7:0]); end
            cmd(6'd41, 32'h4000_0000, 8'hFF);
            get_resp(1, r);
            want = (k < 2) ? 8'h01 : 8'h00;
            total++; if (r[7:0] !== want) begin bad++; $display("FAIL acmd41_r1 got=%h want=%h", r[7:0], want); end
        end
        total++; if (bus.initialized !== 1'b1) begin bad++; $display("FAIL init_flag got=%b want=1", bus.initialized); end
        cmd(6'd58, 32'h0, 8'hFF);
        get_resp(5, r);
        total++; if (r !== 40'h00_C0FF_8000) begin bad++; $display("FAIL cmd58_r3 got=%h want=00c0ff8000", r); end
    endtask

    task automatic test_write();
        logic [39:0] r;
        logic [7:0]  d, b;
        logic [47:0] tail;
        clear_mon();
        cmd(6'd24, 32'h0000_0802, 8'hFF);
        get_resp(1, r);
        total++; if (r[7:0] !== 8'h00) begin bad++; $display("FAIL cmd24_r1 got=%h want=00", r[7:0]); end
        xfer(8'hFF, d);
        xfer(8'hFE, d);
        for (int i = 0; i < 512; i++) begin
            b = i[7:0];
            xfer(b, d);
        end
        xfer(8'hA5, d);
        xfer(8'h5A, d);
        tail = 48'h0;
        for (int i = 0; i < 6; i++) begin
            xfer(8'hFF, d);
            tail = {tail[39:0], d};
        end
        total++; if (tail !== 48'h05_0000_0000_FF) begin bad++; $display("FAIL wr_tail got=%h want=0500000000ff", tail); end
        total++; if (valid_cnt !== 512) begin bad++; $display("FAIL wr_count got=%0d want=512", valid_cnt); end
        total++; if (data_err !== 0) begin bad++; $display("FAIL wr_data_errs got=%0d want=0", data_err); end
        total++; if (first_cnt !== 1 || first_data !== 8'h00) begin bad++; $display("FAIL wr_first got=%0d/%h want=1/00", first_cnt, first_data); end
        total++; if (last_cnt !== 1 || last_data !== 8'hFF) begin bad++; $display("FAIL wr_last got=%0d/%h want=1/ff", last_cnt, last_data); end
        total++; if (bus.wr_addr !== 32'h0000_0802) begin bad++; $display("FAIL wr_addr got=%h want=00000802", bus.wr_addr); end
        total++; if (abort_cnt !== 0) begin bad++; $display("FAIL wr_no_abort got=%0d want=0", abort_cnt); end
    endtask

    task automatic test_abort();
        logic [39:0] r;
        logic [7:0]  d, b;
        clear_mon();
        cmd(6'd24, 32'h0000_1234, 8'hFF);
        get_resp(1, r);
        total++; if (r[7:0] !== 8'h00) begin bad++; $display("FAIL abort_cmd24_r1 got=%h want=00", r[7:0]); end
        xfer(8'hFE, d);
        for (int i = 0; i < 100; i++) begin
            b = i[7:0];
            xfer(b, d);
        end
        #50;
        bus.cs_n = 1'b1;
        #200;
        total++; if (valid_cnt !== 100) begin bad++; $display("FAIL abort_count got=%0d want=100", valid_cnt); end
        total++; if (abort_cnt !== 1) begin bad++; $display("FAIL abort_pulses got=%0d want=1", abort_cnt); end
        total++; if (data_err !== 0) begin bad++; $display("FAIL abort_data_errs got=%0d want=0", data_err); end
        total++; if (bus.miso !== 1'b1) begin bad++; $display("FAIL abort_miso got=%b want=1", bus.miso); end
        total++; if (bus.wr_addr !== 32'h0000_1234) begin bad++; $display("FAIL abort_addr got=%h want=00001234", bus.wr_addr); end
        bus.cs_n = 1'b0;
        #50;
        cmd(6'd13, 32'h0, 8'hFF);
        get_resp(2, r);
        total++; if (r[15:0] !== 16'h0000) begin bad++; $display("FAIL cmd13_r2 got=%h want=0000", r[15:0]); end
        total++; if (bus.initialized !== 1'b1) begin bad++; $display("FAIL abort_init_kept got=%b want=1", bus.initialized); end
    endtask

    task automatic test_illegal();
        logic [39:0] r;
        logic [7:0]  d, b;
        cmd(6'd0, 32'h0, 8'h95);
        get_resp(1, r);
        total++; if (r[7:0] !== 8'h01) begin bad++; $display("FAIL ill_cmd0 got=%h want=01", r[7:0]); end
        total++; if (bus.initialized !== 1'b0) begin bad++; $display("FAIL ill_init_cleared got=%b want=0", bus.initialized); end
        cmd(6'd5, 32'h0, 8'h00);
        get_resp(1, r);
        total++; if (r[7:0] !== 8'h05) begin bad++; $display("FAIL ill_cmd5 got=%h want=05", r[7:0]); end
        cmd(6'd41, 32'h0, 8'hFF);
        get_resp(1, r);
        total++; if (r[7:0] !== 8'h05) begin bad++; $display("FAIL ill_cmd41_noapp got=%h want=05", r[7:0]); end
        cmd(6'd16, 32'd512, 8'hFF);
        get_resp(1, r);
        total++; if (r[7:0] !== 8'h01) begin bad++; $display("FAIL cmd16_512 got=%h want=01", r[7:0]); end
        cmd(6'd16, 32'd513, 8'hFF);
        get_resp(1, r);
        total++; if (r[7:0] !== 8'h41) begin bad++; $display("FAIL cmd16_513 got=%h want=41", r[7:0]); end
        cmd(6'd59, 32'h0, 8'hFF);
        get_resp(1, r);
        total++; if (r[7:0] !== 8'h01) begin bad++; $display("FAIL cmd59 got=%h want=01", r[7:0]); end
        clear_mon();
        cmd(6'd24, 32'h0000_0040, 8'hFF);
        get_resp(1, r);
        total++; if (r[7:0] !== 8'h05) begin bad++; $display("FAIL ill_cmd24 got=%h want=05", r[7:0]); end
        xfer(8'hFE, d);
        for (int i = 0; i < 8; i++) begin
            b = i[7:0];
            xfer(b, d);
        end
        total++; if (valid_cnt !== 0) begin bad++; $display("FAIL ill_cmd24_nodata got=%0d want=0", valid_cnt); end
        total++; if (bus.wr_addr !== 32'h0000_1234) begin bad++; $display("FAIL ill_cmd24_addr got=%h want=00001234", bus.wr_addr); end
        cmd(6'd55, 32'h0, 8'hFF);
        get_resp(1, r);
        cmd(6'd41, 32'h4000_0000, 8'hFF);
        get_resp(1, r);
        total++; if (r[7:0] !== 8'h01) begin bad++; $display("FAIL acmd41_after_cmd0 got=%h want=01", r[7:0]); end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_cmd0();
        test_init();
        test_write();
        test_abort();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
